// File: rtl/issue_pkg.sv
// Shared types and instruction-class helpers for the dual-issue stage.
package issue_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RW   = 4;
  localparam int unsigned IMW  = 5;

  localparam logic [OPW-1:0] OP_NOP    = 4'h0;
  localparam logic [OPW-1:0] OP_ADDI   = 4'h2;
  localparam logic [OPW-1:0] OP_LOAD   = 4'hA;
  localparam logic [OPW-1:0] OP_STORE  = 4'hB;
  localparam logic [OPW-1:0] OP_BRANCH = 4'hC;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [RW-1:0]  des;
    logic [RW-1:0]  s1;
    logic [RW-1:0]  s2;
    logic [IMW-1:0] ime;
  } instr_t;

  function automatic logic writes_rd(instr_t i);
    return !(i.op inside {OP_NOP, OP_STORE, OP_BRANCH}) && (i.des != '0);
  endfunction

  function automatic logic reads_s2(instr_t i);
    return !(i.op inside {OP_ADDI, OP_LOAD});
  endfunction

  function automatic logic is_mem(instr_t i);
    return i.op inside {OP_LOAD, OP_STORE};
  endfunction

  function automatic logic operands_ready(instr_t i, logic [NREG-1:0] busy);
    return !busy[i.s1] && !(reads_s2(i) && busy[i.s2]) && !(writes_rd(i) && busy[i.des]);
  endfunction

  // Younger instruction may not pair with the older one it depends on or shares the mem port with.
  function automatic logic pair_hazard(instr_t o, instr_t y);
    return (writes_rd(o) && ((y.s1 == o.des) || (reads_s2(y) && (y.s2 == o.des)) ||
                             (y.des == o.des))) ||
           (is_mem(o) && is_mem(y));
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy scoreboard: two issue-time set ports, two writeback clear ports.
module issue_scoreboard
  import issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set0_en_i,
  input  logic [RW-1:0]   set0_reg_i,
  input  logic            set1_en_i,
  input  logic [RW-1:0]   set1_reg_i,
  input  logic            clr0_en_i,
  input  logic [RW-1:0]   clr0_reg_i,
  input  logic            clr1_en_i,
  input  logic [RW-1:0]   clr1_reg_i,
  output logic [NREG-1:0] busy_eff_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set0_en_i) set_mask[set0_reg_i] = 1'b1;
    if (set1_en_i) set_mask[set1_reg_i] = 1'b1;
    if (clr0_en_i) clr_mask[clr0_reg_i] = 1'b1;
    if (clr1_en_i) clr_mask[clr1_reg_i] = 1'b1;
    busy_eff_o = busy_q & ~clr_mask;
    // Set is applied after clear so a same-edge set wins; R0 never tracks.
    busy_d     = busy_eff_o | set_mask;
    busy_d[0]  = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// In-order dual-issue stage: holds a decoded pair and issues 0-2 instructions per cycle.
module dual_issue_ctrl
  import issue_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] ins_1_op,
  input  logic [RW-1:0]  ins_1_des,
  input  logic [RW-1:0]  ins_1_s1,
  input  logic [RW-1:0]  ins_1_s2,
  input  logic [IMW-1:0] ins_1_ime,
  input  logic [OPW-1:0] ins_2_op,
  input  logic [RW-1:0]  ins_2_des,
  input  logic [RW-1:0]  ins_2_s1,
  input  logic [RW-1:0]  ins_2_s2,
  input  logic [IMW-1:0] ins_2_ime,
  input  logic           wb0_valid,
  input  logic [RW-1:0]  wb0_reg,
  input  logic           wb1_valid,
  input  logic [RW-1:0]  wb1_reg,
  input  logic           iss_stall,
  output logic           iss0_valid,
  output logic [OPW-1:0] iss0_op,
  output logic [RW-1:0]  iss0_des,
  output logic [RW-1:0]  iss0_s1,
  output logic [RW-1:0]  iss0_s2,
  output logic [IMW-1:0] iss0_ime,
  output logic           iss1_valid,
  output logic [OPW-1:0] iss1_op,
  output logic [RW-1:0]  iss1_des,
  output logic [RW-1:0]  iss1_s1,
  output logic [RW-1:0]  iss1_s2,
  output logic [IMW-1:0] iss1_ime
);

  instr_t ins_1, ins_2;
  instr_t a_q, a_d, b_q, b_d;
  logic   a_v_q, a_v_d, b_v_q, b_v_d;
  instr_t iss0_q, iss0_d, iss1_q, iss1_d;
  logic   iss0_v_q, iss0_v_d, iss1_v_q, iss1_v_d;

  logic [NREG-1:0] busy_eff;
  logic            a_iss, b_iss, accept;

  assign ins_1 = '{op: ins_1_op, des: ins_1_des, s1: ins_1_s1, s2: ins_1_s2, ime: ins_1_ime};
  assign ins_2 = '{op: ins_2_op, des: ins_2_des, s1: ins_2_s1, s2: ins_2_s2, ime: ins_2_ime};

  issue_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set0_en_i (a_iss & writes_rd(a_q)),
    .set0_reg_i(a_q.des),
    .set1_en_i (b_iss & writes_rd(b_q)),
    .set1_reg_i(b_q.des),
    .clr0_en_i (wb0_valid),
    .clr0_reg_i(wb0_reg),
    .clr1_en_i (wb1_valid),
    .clr1_reg_i(wb1_reg),
    .busy_eff_o(busy_eff)
  );

  always_comb begin
    a_iss = a_v_q & ~iss_stall & operands_ready(a_q, busy_eff);
    b_iss = b_v_q & ~iss_stall & operands_ready(b_q, busy_eff) &
            (a_v_q ? (a_iss & ~pair_hazard(a_q, b_q)) : 1'b1);
    in_ready = ~rst & (~a_v_q | a_iss) & (~b_v_q | b_iss);
    accept   = in_valid & in_ready;

    a_d   = a_q;
    b_d   = b_q;
    a_v_d = a_v_q & ~a_iss;
    b_v_d = b_v_q & ~b_iss;
    if (accept) begin
      a_d   = ins_1;
      a_v_d = (ins_1.op != OP_NOP);
      b_d   = ins_2;
      b_v_d = (ins_2.op != OP_NOP);
    end
    // Keep the oldest pending instruction in slot A.
    if (!a_v_d && b_v_d) begin
      a_d   = b_d;
      a_v_d = 1'b1;
      b_v_d = 1'b0;
    end

    iss0_v_d = a_iss | b_iss;
    iss1_v_d = a_iss & b_iss;
    iss0_d   = iss0_q;
    iss1_d   = iss1_q;
    if (a_iss) begin
      iss0_d = a_q;
    end else if (b_iss) begin
      iss0_d = b_q;
    end
    if (a_iss && b_iss) iss1_d = b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      a_v_q    <= 1'b0;
      b_v_q    <= 1'b0;
      iss0_q   <= '0;
      iss1_q   <= '0;
      iss0_v_q <= 1'b0;
      iss1_v_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      a_v_q    <= a_v_d;
      b_v_q    <= b_v_d;
      iss0_q   <= iss0_d;
      iss1_q   <= iss1_d;
      iss0_v_q <= iss0_v_d;
      iss1_v_q <= iss1_v_d;
    end
  end

  assign iss0_valid = iss0_v_q;
  assign iss0_op    = iss0_q.op;
  assign iss0_des   = iss0_q.des;
  assign iss0_s1    = iss0_q.s1;
  assign iss0_s2    = iss0_q.s2;
  assign iss0_ime   = iss0_q.ime;
  assign iss1_valid = iss1_v_q;
  assign iss1_op    = iss1_q.op;
  assign iss1_des   = iss1_q.des;
  assign iss1_s1    = iss1_q.s1;
  assign iss1_s2    = iss1_q.s2;
  assign iss1_ime   = iss1_q.ime;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed vector table, reset corner cases, random vs queue model.
module tb_dual_issue_ctrl;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] des;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [4:0] ime;
  } ins_t;

  typedef struct {
    logic       inv;
    ins_t       a;
    ins_t       b;
    logic       w0v;
    logic [3:0] w0r;
    logic       w1v;
    logic [3:0] w1r;
    logic       st;
    logic       rdy;
    logic       v0;
    logic       v1;
    logic [3:0] op0;
    logic [3:0] des0;
    logic [3:0] des1;
  } row_t;

  logic       clk, rst, in_valid, in_ready;
  ins_t       in1, in2;
  logic       wb0_valid, wb1_valid, iss_stall;
  logic [3:0] wb0_reg, wb1_reg;
  logic       iss0_valid, iss1_valid;
  ins_t       out0, out1;

  int n_checks = 0;
  int n_fail   = 0;
  row_t rows[$];

  dual_issue_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ins_1_op  (in1.op),
    .ins_1_des (in1.des),
    .ins_1_s1  (in1.s1),
    .ins_1_s2  (in1.s2),
    .ins_1_ime (in1.ime),
    .ins_2_op  (in2.op),
    .ins_2_des (in2.des),
    .ins_2_s1  (in2.s1),
    .ins_2_s2  (in2.s2),
    .ins_2_ime (in2.ime),
    .wb0_valid (wb0_valid),
    .wb0_reg   (wb0_reg),
    .wb1_valid (wb1_valid),
    .wb1_reg   (wb1_reg),
    .iss_stall (iss_stall),
    .iss0_valid(iss0_valid),
    .iss0_op   (out0.op),
    .iss0_des  (out0.des),
    .iss0_s1   (out0.s1),
    .iss0_s2   (out0.s2),
    .iss0_ime  (out0.ime),
    .iss1_valid(iss1_valid),
    .iss1_op   (out1.op),
    .iss1_des  (out1.des),
    .iss1_s1   (out1.s1),
    .iss1_s2   (out1.s2),
    .iss1_ime  (out1.ime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic [3:0] op, input logic [3:0] des,
                              input logic [3:0] s1, input logic [3:0] s2);
    return '{op: op, des: des, s1: s1, s2: s2, ime: {1'b1, des}};
  endfunction

  task automatic add_row(input logic inv, input ins_t a, input ins_t b,
                         input logic w0v, input logic [3:0] w0r,
                         input logic w1v, input logic [3:0] w1r, input logic st,
                         input logic rdy, input logic v0, input logic v1,
                         input logic [3:0] op0, input logic [3:0] des0, input logic [3:0] des1);
    row_t r;
    r = '{inv, a, b, w0v, w0r, w1v, w1r, st, rdy, v0, v1, op0, des0, des1};
    rows.push_back(r);
  endtask

  // Reference rules, written from the instruction classes.
  function automatic bit m_wr(input ins_t i);
    return (i.op != 4'h0) && (i.op != 4'hB) && (i.op != 4'hC) && (i.des != 4'd0);
  endfunction
  function automatic bit m_rs2(input ins_t i);
    return (i.op != 4'h2) && (i.op != 4'hA);
  endfunction
  function automatic bit m_mem(input ins_t i);
    return (i.op == 4'hA) || (i.op == 4'hB);
  endfunction
  function automatic bit m_ok(input ins_t i, input logic [15:0] be);
    if (be[i.s1]) return 0;
    if (m_rs2(i) && be[i.s2]) return 0;
    if (m_wr(i) && be[i.des]) return 0;
    return 1;
  endfunction
  function automatic bit m_conf(input ins_t o, input ins_t y);
    if (m_mem(o) && m_mem(y)) return 1;
    if (!m_wr(o)) return 0;
    return (y.s1 == o.des) || (m_rs2(y) && (y.s2 == o.des)) || (y.des == o.des);
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    wb0_valid = 1'b0;
    wb0_reg   = 4'd0;
    wb1_valid = 1'b0;
    wb1_reg   = 4'd0;
    iss_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    ins_t       nop;
    ins_t       hq[$];
    logic [15:0] mb, be;
    ins_t       e0, e1;
    logic       ev0, ev1, erdy;
    int         n;
    logic [3:0] ops[8];

    nop = '0;
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_iss0_valid", 32'(iss0_valid), 32'd0);
    check("rst_iss1_valid", 32'(iss1_valid), 32'd0);
    check("rst_iss0_fields", 32'(out0), 32'd0);
    check("rst_iss1_fields", 32'(out1), 32'd0);
    rst = 1'b0;

    // inv, A, B, wb0, wb1, stall | ready, v0, v1, op0, des0, des1 (outputs after this edge)
    add_row(1, mk(1, 1, 2, 3), mk(1, 4, 5, 6), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 4);
    add_row(1, mk(1, 7, 1, 0), mk(1, 8, 0, 0), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 1, 1, 1, 4, 0, 1, 1, 1, 1, 7, 8);
    add_row(1, mk(1, 1, 2, 3), mk(3, 5, 1, 4), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 1, 1, 0, 0, 0, 1, 1, 0, 3, 5, 0);
    add_row(1, mk(4'hA, 2, 0, 0), mk(4'hB, 3, 0, 0), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 0, 0, 1, 0, 4'hA, 2, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 0, 1, 1, 0, 4'hB, 3, 0);
    add_row(1, mk(1, 0, 4, 6), mk(1, 3, 0, 0), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 3);
    add_row(1, mk(1, 9, 0, 0), mk(1, 10, 0, 0), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 0, 1, 1, 1, 1, 9, 10);
    add_row(0, nop, nop, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(1, mk(1, 7, 0, 0), nop, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 1, 7, 0, 0, 0, 1, 1, 0, 1, 7, 0);
    add_row(1, mk(1, 11, 7, 0), nop, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_row(0, nop, nop, 1, 7, 0, 0, 0, 1, 1, 0, 1, 11, 0);

    for (int i = 0; i < rows.size(); i++) begin
      in_valid  = rows[i].inv;
      in1       = rows[i].a;
      in2       = rows[i].b;
      wb0_valid = rows[i].w0v;
      wb0_reg   = rows[i].w0r;
      wb1_valid = rows[i].w1v;
      wb1_reg   = rows[i].w1r;
      iss_stall = rows[i].st;
      #1;
      check($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(rows[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("row%0d_iss0_valid", i), 32'(iss0_valid), 32'(rows[i].v0));
      check($sformatf("row%0d_iss1_valid", i), 32'(iss1_valid), 32'(rows[i].v1));
      if (rows[i].v0) begin
        check($sformatf("row%0d_iss0_op", i), 32'(out0.op), 32'(rows[i].op0));
        check($sformatf("row%0d_iss0_des", i), 32'(out0.des), 32'(rows[i].des0));
      end
      if (rows[i].v1) check($sformatf("row%0d_iss1_des", i), 32'(out1.des), 32'(rows[i].des1));
    end

    // Asynchronous reset while an issue is visible; busy[11] must be forgotten.
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_iss0_valid", 32'(iss0_valid), 32'd0);
    check("async_rst_iss0_des", 32'(out0.des), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in1      = mk(1, 12, 11, 11);
    in2      = mk(1, 13, 11, 0);
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    check("post_rst_iss0_valid", 32'(iss0_valid), 32'd1);
    check("post_rst_iss1_valid", 32'(iss1_valid), 32'd1);
    check("post_rst_iss1_des", 32'(out1.des), 32'd13);

    // Randomized run against a queue-based model.
    do_reset();
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hA, 4'hB, 4'hC, 4'h5};
    hq.delete();
    mb  = '0;
    e0  = '0;
    e1  = '0;
    ev0 = 1'b0;
    ev1 = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in1       = '{op: ops[$urandom_range(0, 7)], des: 4'($urandom_range(0, 7)),
                    s1: 4'($urandom_range(0, 7)), s2: 4'($urandom_range(0, 7)),
                    ime: 5'($urandom_range(0, 31))};
      in2       = '{op: ops[$urandom_range(0, 7)], des: 4'($urandom_range(0, 7)),
                    s1: 4'($urandom_range(0, 7)), s2: 4'($urandom_range(0, 7)),
                    ime: 5'($urandom_range(0, 31))};
      wb0_valid = ($urandom_range(0, 1) == 1);
      wb0_reg   = 4'($urandom_range(0, 7));
      wb1_valid = ($urandom_range(0, 3) == 0);
      wb1_reg   = 4'($urandom_range(0, 7));
      iss_stall = ($urandom_range(0, 4) == 0);

      be = mb;
      if (wb0_valid) be[wb0_reg] = 1'b0;
      if (wb1_valid) be[wb1_reg] = 1'b0;
      n = 0;
      if (!iss_stall && hq.size() > 0 && m_ok(hq[0], be)) begin
        n = 1;
        if (hq.size() > 1 && m_ok(hq[1], be) && !m_conf(hq[0], hq[1])) n = 2;
      end
      erdy = (n == hq.size());
      ev0  = (n >= 1);
      ev1  = (n == 2);
      if (n >= 1) e0 = hq[0];
      if (n == 2) e1 = hq[1];
      mb = be;
      for (int k = 0; k < n; k++) begin
        if (m_wr(hq[0])) mb[hq[0].des] = 1'b1;
        void'(hq.pop_front());
      end
      mb[0] = 1'b0;
      if (in_valid && erdy) begin
        if (in1.op != 4'h0) hq.push_back(in1);
        if (in2.op != 4'h0) hq.push_back(in2);
      end

      #1;
      check("rand_in_ready", 32'(in_ready), 32'(erdy));
      @(posedge clk);
      #1;
      check("rand_iss0_valid", 32'(iss0_valid), 32'(ev0));
      check("rand_iss1_valid", 32'(iss1_valid), 32'(ev1));
      check("rand_iss0_fields", 32'(out0), 32'(e0));
      check("rand_iss1_fields", 32'(out1), 32'(e1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
